// File: rtl/fitness_eval_ctrl.sv
// OneMax fitness front end for the population sorter: loads N chromosomes, starts the sort, captures best/worst.
// Optional FIT_SUM_EN adds fit_sum, the total of stored fitness values for roulette selection.
module fitness_eval_ctrl #(
    parameter int N       = 10,
    parameter int CHROM_W = 16,
    parameter int WIDTH   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       eval_start,
    input  logic                       chrom_valid,
    input  logic [CHROM_W-1:0]         chrom_data,
    output logic                       chrom_ready,
    output logic [N-1:0][WIDTH-1:0]    fitness_array,
    output logic                       sort_start,
    input  logic                       sort_done,
    input  logic [N-1:0][WIDTH-1:0]    sorted_array,
    output logic [WIDTH-1:0]           best_fitness,
    output logic [WIDTH-1:0]           worst_fitness,
    output logic                       eval_done,
`ifdef FIT_SUM_EN
    output logic [WIDTH+$clog2(N):0]   fit_sum,
`endif
    output logic                       busy
);

    // state | meaning
    // IDLE  | waiting for eval_start
    // LOAD  | accepting N chromosome beats, storing popcounts
    // START | one-cycle sort_start; sort_done ignored (may be stale)
    // WAIT  | waiting for sort_done, then capture best/worst
    // DONE  | one-cycle eval_done
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(CHROM_W + 1);
    localparam int SUM_W = WIDTH + $clog2(N) + 1;
    localparam logic [WIDTH-1:0] FIT_MAX = '1;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [N-1:0][WIDTH-1:0]   fit_q, fit_d;
    logic [WIDTH-1:0]          best_q, best_d, worst_q, worst_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic                      ready_q, ready_d;
    logic                      start_q, start_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic [CNT_W-1:0]          pop_cnt;
    logic [WIDTH-1:0]          fit_sat;
    logic                      beat;
    logic                      sorted_unused;

    // Only the two ends of the sorted array matter here.
    assign sorted_unused = ^sorted_array;

    always_comb begin
        pop_cnt = '0;
        for (int b = 0; b < CHROM_W; b++) begin
            pop_cnt = pop_cnt + CNT_W'(chrom_data[b]);
        end
        if (int'(pop_cnt) > int'(FIT_MAX)) begin
            fit_sat = FIT_MAX;
        end else begin
            fit_sat = WIDTH'(pop_cnt);
        end
    end

    assign beat = chrom_valid & ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fit_d   = fit_q;
        best_d  = best_q;
        worst_d = worst_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (eval_start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    fit_d[idx_q] = fit_sat;
                    idx_d        = idx_q + IDX_W'(1);
                    sum_d        = sum_q + SUM_W'(fit_sat);
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = START;
                        idx_d   = '0;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (sort_done) begin
                    best_d  = sorted_array[N-1];
                    worst_d = sorted_array[0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered decodes of the next state, so they are glitch-free flops.
        ready_d = (state_d == LOAD);
        start_d = (state_d == START);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fit_q   <= '0;
            best_q  <= '0;
            worst_q <= '0;
            sum_q   <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fit_q   <= fit_d;
            best_q  <= best_d;
            worst_q <= worst_d;
            sum_q   <= sum_d;
            ready_q <= ready_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign chrom_ready   = ready_q;
    assign fitness_array = fit_q;
    assign sort_start    = start_q;
    assign best_fitness  = best_q;
    assign worst_fitness = worst_q;
    assign eval_done     = done_q;
    assign busy          = busy_q;

`ifdef FIT_SUM_EN
    assign fit_sum = sum_q;
`else
    logic sum_unused;
    assign sum_unused = ^sum_q;
`endif

endmodule

// File: doc/fitness_eval_ctrl.md
Name: fitness_eval_ctrl

Overview:
Front end and initiator for the population sorter in the GA datapath. Accepts N chromosomes over a valid/ready stream and computes each one's fitness as a popcount (OneMax), held in a fitness array. It then issues a single-cycle start to the sorter, waits for the sorter's done, and captures best/worst fitness from the sorted array for the selection stage.

Parameters:
N, 10, population size (number of chromosomes per evaluation); N >= 2
CHROM_W, 16, chromosome width in bits
WIDTH, 5, fitness width; matches sorter WIDTH

Ports:
clk  input  1  clock
rst  input  1  reset
eval_start  input  1  begin evaluation of a new population (sampled in IDLE only)
chrom_valid  input  1  chromosome beat valid
chrom_data  input  CHROM_W  chromosome bits
chrom_ready  output  1  block can accept a chromosome beat
fitness_array  output  WIDTH x N  per-chromosome fitness, index = arrival order; drives sorter input
sort_start  output  1  single-cycle sorter start pulse
sort_done  input  1  sorter done (level; sorted_array valid while high)
sorted_array  input  WIDTH x N  ascending sorted fitness from sorter
best_fitness  output  WIDTH  max fitness of last completed evaluation
worst_fitness  output  WIDTH  min fitness of last completed evaluation
eval_done  output  1  single-cycle pulse: best/worst updated
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. All outputs 0, fitness_array all 0, index 0, state IDLE.
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE: chrom_ready=0, busy=0. If eval_start=1, go to LOAD next cycle and clear index. eval_start is ignored in all other states.
- LOAD: chrom_ready=1. On chrom_valid&chrom_ready:
  - fitness_array[idx] <= popcount(chrom_data), saturated to 2^WIDTH-1 if popcount exceeds it.
  - idx <= idx+1.
  - The beat with idx=N-1 moves the FSM to START. Exactly N beats are accepted; chrom_ready drops the cycle after the N-th beat.
  - Gaps in chrom_valid stall without side effects.
- START: sort_start=1 for exactly this one cycle (registered). Go to WAIT next cycle. sort_done is not sampled in START, so a stale done from the previous run is never accepted. The sorter clears done on the edge that ends START.
- WAIT: sort_start=0. On the first cycle with sort_done=1:
  - best_fitness <= sorted_array[N-1].
  - worst_fitness <= sorted_array[0].
  - Go to DONE.
  - No timeout.
- DONE: eval_done=1 for this one cycle, with best/worst already updated. Return to IDLE.
- fitness_array is held stable from the end of LOAD until the next LOAD begins, as the sorter's copy stage requires.
- best/worst hold their values until the next DONE.
- Latency: eval_start to first chrom_ready is 1 cycle. Last beat to sort_start is 1 cycle. sort_done (in WAIT) to eval_done is 1 cycle.
- Reset mid-operation: immediate return to IDLE with all state cleared; no sort_start is emitted afterwards.

Optional Feature:
- Macro: FIT_SUM_EN.
- Defined:
  - Adds output fit_sum, width WIDTH+$clog2(N)+1: the total of the stored (post-saturation) fitness values, for roulette selection.
  - Accumulated during LOAD and cleared on LOAD entry.
  - Valid from START onward; holds until the next LOAD entry; reset 0.
- Undefined: no fit_sum port and no accumulator.

Test Plan:
1. N=10, CHROM_W=16, WIDTH=5. Chromosomes with popcounts 3,16,0,7,7,1,12,5,9,2, back-to-back; behavioural sorter model. Required:
   - fitness_array = {3,16,0,7,7,1,12,5,9,2}.
   - One sort_start pulse, 1 cycle after the 10th beat.
   - eval_done one cycle after sort_done with best=16, worst=0.
   - fit_sum=62 with FIT_SUM_EN.
2. Same data with chrom_valid toggled 1-0-0-1 randomly -> identical fitness_array/best/worst. chrom_ready low exactly 1 cycle after the 10th accepted beat; no extra beats stored.
3. sort_done held high from the previous run into the new START cycle, then low, then high 12 cycles later -> eval_done fires only after the later high, never in START+1.
4. rst asserted after 4 beats of LOAD -> all outputs 0 immediately, no sort_start. A subsequent eval_start plus a full 10 beats completes normally.
5. eval_start pulsed during LOAD and WAIT -> no effect on index or state; exactly one eval_done per accepted eval_start.
6. CHROM_W=40, WIDTH=5, all-ones chromosome -> stored fitness 31 (saturated); best_fitness=31.
